// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared encodings for the memory-access/writeback stage
package wb_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_CSR  = 2'b11;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - Execute-to-writeback instruction handshake bundle
interface wb_stage_if #(
    parameter int XLEN = 32
) ();
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_alu_out;
    logic [4:0]      ex_rd;
    logic [1:0]      ex_wb_sel;
    logic [2:0]      ex_ld_sel;
    logic            ex_reg_wen;
    logic [XLEN-1:0] csr_rdata;

    modport master (
        output ex_valid, ex_pc, ex_alu_out, ex_rd, ex_wb_sel, ex_ld_sel,
               ex_reg_wen, csr_rdata,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_pc, ex_alu_out, ex_rd, ex_wb_sel, ex_ld_sel,
               ex_reg_wen, csr_rdata,
        output ex_ready
    );
endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts a raw memory word by the byte offset and extends it
module load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                ld_sel,
    input  logic [XLEN-1:0]           raw,
    output logic [XLEN-1:0]           data,
    output logic                      illegal
);
    logic [XLEN-1:0] shifted;

    assign shifted = raw >> {offset, 3'b000};

    // Size casts of signed slices sign-extend, which also covers LW at XLEN=32.
    always_comb begin
        data    = '0;
        illegal = 1'b0;
        case (ld_sel)
            LD_B:  data = XLEN'($signed(shifted[7:0]));
            LD_H:  data = XLEN'($signed(shifted[15:0]));
            LD_W:  data = XLEN'($signed(shifted[31:0]));
            LD_BU: data = XLEN'(shifted[7:0]);
            LD_HU: data = XLEN'(shifted[15:0]);
            LD_D: begin
                if (XLEN == 64) data = shifted;
                else            illegal = 1'b1;
            end
            LD_WU: begin
                if (XLEN == 64) data = XLEN'(shifted[31:0]);
                else            illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - memory-access/writeback stage with variable-latency load wait
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_if.slave       ex_bus,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_wen,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_err
);
    localparam int OFFW = $clog2(XLEN/8);
    localparam int CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [4:0]      ld_rd;
    logic            ld_wen;
    logic [2:0]      ld_sel_q;
    logic [OFFW-1:0] ld_off;

    logic            accept;
    logic            is_load;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] ld_data;
    logic            ld_illegal;

    logic            nxt_valid, nxt_wen, nxt_err;
    logic [4:0]      nxt_rd;
    logic [XLEN-1:0] nxt_data;

    assign ex_bus.ex_ready = (state == IDLE);
    assign accept          = ex_bus.ex_valid && (state == IDLE);
    assign is_load         = (ex_bus.ex_wb_sel == WB_DMEM);

    load_align #(.XLEN(XLEN)) u_load_align (
        .offset  (ld_off),
        .ld_sel  (ld_sel_q),
        .raw     (dmem_rdata),
        .data    (ld_data),
        .illegal (ld_illegal)
    );

    always_comb begin
        case (ex_bus.ex_wb_sel)
            WB_PC4:  ex_result = ex_bus.ex_pc + XLEN'(4);
            WB_CSR:  ex_result = ex_bus.csr_rdata;
            default: ex_result = ex_bus.ex_alu_out;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept && is_load) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
            end
            WAIT: begin
                if (dmem_resp_valid || (cnt == CNT_LAST)) state_nxt = IDLE;
                else                                      cnt_nxt   = cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes default low; rd/data hold so the forwarding network sees stable values.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_wen   = 1'b0;
        nxt_err   = 1'b0;
        nxt_rd    = wb_rd;
        nxt_data  = wb_data;
        case (state)
            IDLE: begin
                if (accept && !is_load) begin
                    nxt_valid = 1'b1;
                    nxt_rd    = ex_bus.ex_rd;
                    nxt_data  = ex_result;
                    nxt_wen   = ex_bus.ex_reg_wen && (ex_bus.ex_rd != 5'd0);
                end
                if (dmem_resp_valid) nxt_err = 1'b1;
            end
            WAIT: begin
                if (dmem_resp_valid) begin
                    nxt_valid = 1'b1;
                    nxt_rd    = ld_rd;
                    nxt_data  = ld_data;
                    nxt_err   = ld_illegal;
                    nxt_wen   = ld_wen && (ld_rd != 5'd0) && !ld_illegal;
                end else if (cnt == CNT_LAST) begin
                    nxt_valid = 1'b1;
                    nxt_rd    = ld_rd;
                    nxt_data  = '0;
                    nxt_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ld_rd    <= '0;
            ld_wen   <= 1'b0;
            ld_sel_q <= '0;
            ld_off   <= '0;
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_err   <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wb_valid <= nxt_valid;
            wb_wen   <= nxt_wen;
            wb_err   <= nxt_err;
            wb_rd    <= nxt_rd;
            wb_data  <= nxt_data;
            if (accept && is_load) begin
                ld_rd    <= ex_bus.ex_rd;
                ld_wen   <= ex_bus.ex_reg_wen;
                ld_sel_q <= ex_bus.ex_ld_sel;
                ld_off   <= ex_bus.ex_alu_out[OFFW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector bench for wb_stage at XLEN 32 and 64
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel64 = 1'b0;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_wb_sel = 2'b00;
    logic [2:0]  ex_ld_sel = 3'b000;
    logic        ex_reg_wen = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [63:0] ex_pc = '0;
    logic [63:0] ex_alu_out = '0;
    logic [63:0] csr_rdata = '0;
    logic        resp = 1'b0;
    logic [63:0] rdata = '0;

    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32)) if32 ();
    wb_stage_if #(.XLEN(64)) if64 ();

    assign if32.ex_valid   = ex_valid && !sel64;
    assign if32.ex_pc      = ex_pc[31:0];
    assign if32.ex_alu_out = ex_alu_out[31:0];
    assign if32.ex_rd      = ex_rd;
    assign if32.ex_wb_sel  = ex_wb_sel;
    assign if32.ex_ld_sel  = ex_ld_sel;
    assign if32.ex_reg_wen = ex_reg_wen;
    assign if32.csr_rdata  = csr_rdata[31:0];

    assign if64.ex_valid   = ex_valid && sel64;
    assign if64.ex_pc      = ex_pc;
    assign if64.ex_alu_out = ex_alu_out;
    assign if64.ex_rd      = ex_rd;
    assign if64.ex_wb_sel  = ex_wb_sel;
    assign if64.ex_ld_sel  = ex_ld_sel;
    assign if64.ex_reg_wen = ex_reg_wen;
    assign if64.csr_rdata  = csr_rdata;

    logic        w32_valid, w32_wen, w32_err;
    logic [4:0]  w32_rd;
    logic [31:0] w32_data;
    logic        w64_valid, w64_wen, w64_err;
    logic [4:0]  w64_rd;
    logic [63:0] w64_data;

    wb_stage #(.XLEN(32), .TIMEOUT(4)) dut32 (
        .clk             (clk),
        .rst             (rst),
        .ex_bus          (if32),
        .dmem_resp_valid (resp && !sel64),
        .dmem_rdata      (rdata[31:0]),
        .wb_valid        (w32_valid),
        .wb_wen          (w32_wen),
        .wb_rd           (w32_rd),
        .wb_data         (w32_data),
        .wb_err          (w32_err)
    );

    wb_stage #(.XLEN(64), .TIMEOUT(4)) dut64 (
        .clk             (clk),
        .rst             (rst),
        .ex_bus          (if64),
        .dmem_resp_valid (resp && sel64),
        .dmem_rdata      (rdata),
        .wb_valid        (w64_valid),
        .wb_wen          (w64_wen),
        .wb_rd           (w64_rd),
        .wb_data         (w64_data),
        .wb_err          (w64_err)
    );

    logic        o_ready, o_valid, o_wen, o_err;
    logic [4:0]  o_rd;
    logic [63:0] o_data;

    assign o_ready = sel64 ? if64.ex_ready : if32.ex_ready;
    assign o_valid = sel64 ? w64_valid : w32_valid;
    assign o_wen   = sel64 ? w64_wen   : w32_wen;
    assign o_err   = sel64 ? w64_err   : w32_err;
    assign o_rd    = sel64 ? w64_rd    : w32_rd;
    assign o_data  = sel64 ? w64_data  : {32'h0, w32_data};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          x64;
        logic [1:0]  wsel;
        logic [2:0]  lsel;
        logic        rwen;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] csr;
        logic [63:0] rdat;
        int          dly;     // response cycle after accept; 0 = never respond
        logic        e_wen;
        logic        e_err;
        bit          cd;      // compare wb_data
        logic [63:0] e_data;
    } vec_t;

    vec_t tv[$];

    task automatic add(input bit x64, input logic [1:0] wsel, input logic [2:0] lsel,
                       input logic rwen, input logic [4:0] rd, input logic [63:0] pc,
                       input logic [63:0] alu, input logic [63:0] csr, input logic [63:0] rdat,
                       input int dly, input logic e_wen, input logic e_err, input bit cd,
                       input logic [63:0] e_data);
        vec_t v;
        v.x64 = x64; v.wsel = wsel; v.lsel = lsel; v.rwen = rwen; v.rd = rd;
        v.pc = pc; v.alu = alu; v.csr = csr; v.rdat = rdat; v.dly = dly;
        v.e_wen = e_wen; v.e_err = e_err; v.cd = cd; v.e_data = e_data;
        tv.push_back(v);
    endtask

    // Entered and left on a negedge; the next instruction is driven in the result cycle.
    task automatic run_vec(input vec_t v);
        int waits;
        sel64      = v.x64;
        ex_wb_sel  = v.wsel;
        ex_ld_sel  = v.lsel;
        ex_reg_wen = v.rwen;
        ex_rd      = v.rd;
        ex_pc      = v.pc;
        ex_alu_out = v.alu;
        csr_rdata  = v.csr;
        ex_valid   = 1'b1;
        chk("accept_ready", {63'h0, o_ready}, 64'h1);
        @(negedge clk);
        ex_valid = 1'b0;
        if (v.wsel == 2'b01) begin
            waits = (v.dly == 0) ? 4 : v.dly;
            for (int k = 1; k < waits; k++) begin
                chk("wait_ready", {63'h0, o_ready}, 64'h0);
                chk("wait_valid", {63'h0, o_valid}, 64'h0);
                @(negedge clk);
            end
            chk("wait_ready", {63'h0, o_ready}, 64'h0);
            if (v.dly != 0) begin
                resp  = 1'b1;
                rdata = v.rdat;
            end
            @(negedge clk);
            resp = 1'b0;
        end
        chk("wb_valid", {63'h0, o_valid}, 64'h1);
        chk("wb_wen",   {63'h0, o_wen},   {63'h0, v.e_wen});
        chk("wb_err",   {63'h0, o_err},   {63'h0, v.e_err});
        chk("wb_rd",    {59'h0, o_rd},    {59'h0, v.rd});
        if (v.cd) chk("wb_data", o_data, v.e_data);
        chk("ready_after", {63'h0, o_ready}, 64'h1);
    endtask

    initial begin
        //   x64 wsel   lsel    wen rd     pc                     alu                    csr                    rdata                  dly e_wen e_err cd e_data
        add(0, 2'b00, 3'b000, 1, 5'd5,  64'h0,                 64'h1234,              64'h0,                 64'h0,                 0, 1, 0, 1, 64'h1234);
        add(0, 2'b01, 3'b000, 1, 5'd6,  64'h0,                 64'h103,               64'h0,                 64'h80FF_0000,         3, 1, 0, 1, 64'hFFFF_FF80);
        add(0, 2'b01, 3'b101, 1, 5'd7,  64'h0,                 64'h102,               64'h0,                 64'hBEEF_0000,         1, 1, 0, 1, 64'h0000_BEEF);
        add(0, 2'b01, 3'b001, 1, 5'd7,  64'h0,                 64'h102,               64'h0,                 64'hBEEF_0000,         1, 1, 0, 1, 64'hFFFF_BEEF);
        add(0, 2'b10, 3'b000, 1, 5'd0,  64'hFFFF_FFFC,         64'h0,                 64'h0,                 64'h0,                 0, 0, 0, 1, 64'h0);
        add(0, 2'b11, 3'b000, 1, 5'd10, 64'h0,                 64'h0,                 64'hDEAD_BEEF,         64'h0,                 0, 1, 0, 1, 64'hDEAD_BEEF);
        add(0, 2'b00, 3'b000, 0, 5'd3,  64'h0,                 64'h55,                64'h0,                 64'h0,                 0, 0, 0, 1, 64'h55);
        add(0, 2'b01, 3'b011, 1, 5'd8,  64'h0,                 64'h0,                 64'h0,                 64'h1234_5678,         2, 0, 1, 1, 64'h0);
        add(0, 2'b01, 3'b100, 1, 5'd12, 64'h0,                 64'h1,                 64'h0,                 64'h0000_8100,         2, 1, 0, 1, 64'h81);
        add(0, 2'b01, 3'b010, 1, 5'd13, 64'h0,                 64'h0,                 64'h0,                 64'h8765_4321,         1, 1, 0, 1, 64'h8765_4321);
        add(0, 2'b01, 3'b010, 1, 5'd9,  64'h0,                 64'h0,                 64'h0,                 64'h0,                 0, 0, 1, 0, 64'h0);
        add(1, 2'b01, 3'b011, 1, 5'd11, 64'h0,                 64'h0,                 64'h0,                 64'h8000_0000_0000_0001, 2, 1, 0, 1, 64'h8000_0000_0000_0001);
        add(1, 2'b01, 3'b110, 1, 5'd14, 64'h0,                 64'h4,                 64'h0,                 64'h8000_0000_1234_5678, 1, 1, 0, 1, 64'h0000_0000_8000_0000);
        add(1, 2'b01, 3'b010, 1, 5'd15, 64'h0,                 64'h4,                 64'h0,                 64'h8000_0000_1234_5678, 2, 1, 0, 1, 64'hFFFF_FFFF_8000_0000);
        add(1, 2'b01, 3'b000, 1, 5'd16, 64'h0,                 64'h7,                 64'h0,                 64'h7F00_0000_0000_0000, 3, 1, 0, 1, 64'h7F);
        add(1, 2'b10, 3'b000, 1, 5'd1,  64'h0000_0000_FFFF_FFFC, 64'h0,               64'h0,                 64'h0,                 0, 1, 0, 1, 64'h0000_0001_0000_0000);
        add(1, 2'b01, 3'b111, 1, 5'd17, 64'h0,                 64'h0,                 64'h0,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 1, 64'h0);
        add(1, 2'b01, 3'b001, 1, 5'd18, 64'h0,                 64'h0,                 64'h0,                 64'h0,                 0, 0, 1, 0, 64'h0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready32", {63'h0, if32.ex_ready}, 64'h1);
        chk("rst_ready64", {63'h0, if64.ex_ready}, 64'h1);
        chk("rst_valid32", {63'h0, w32_valid}, 64'h0);
        chk("rst_valid64", {63'h0, w64_valid}, 64'h0);
        chk("rst_err32",   {63'h0, w32_err},   64'h0);
        chk("rst_wen64",   {63'h0, w64_wen},   64'h0);
        chk("rst_rd32",    {59'h0, w32_rd},    64'h0);
        chk("rst_data64",  w64_data,           64'h0);

        foreach (tv[i]) run_vec(tv[i]);

        // Back-to-back ALU instructions retire on consecutive cycles.
        sel64 = 1'b0; ex_wb_sel = 2'b00; ex_reg_wen = 1'b1;
        ex_valid = 1'b1; ex_rd = 5'd1; ex_alu_out = 64'h11;
        @(negedge clk);
        chk("b2b_ready", {63'h0, o_ready}, 64'h1);
        chk("b2b_data0", o_data, 64'h11);
        ex_rd = 5'd2; ex_alu_out = 64'h22;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("b2b_valid1", {63'h0, o_valid}, 64'h1);
        chk("b2b_rd1",    {59'h0, o_rd},    64'h2);
        chk("b2b_data1",  o_data,           64'h22);
        @(negedge clk);
        chk("b2b_idle", {63'h0, o_valid}, 64'h0);

        // Response with no outstanding load: error pulse only.
        resp = 1'b1; rdata = 64'hAAAA_AAAA;
        @(negedge clk);
        resp = 1'b0;
        chk("spur_err",   {63'h0, o_err},   64'h1);
        chk("spur_valid", {63'h0, o_valid}, 64'h0);
        chk("spur_wen",   {63'h0, o_wen},   64'h0);
        chk("spur_ready", {63'h0, o_ready}, 64'h1);
        @(negedge clk);
        chk("spur_pulse", {63'h0, o_err}, 64'h0);

        // Reset while a load waits aborts silently.
        sel64 = 1'b1; ex_wb_sel = 2'b01; ex_ld_sel = 3'b011; ex_rd = 5'd20; ex_alu_out = 64'h0;
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstw_ready", {63'h0, o_ready}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_valid", {63'h0, o_valid}, 64'h0);
        chk("rstw_err",   {63'h0, o_err},   64'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rstw_quiet_valid", {63'h0, o_valid}, 64'h0);
            chk("rstw_quiet_err",   {63'h0, o_err},   64'h0);
            chk("rstw_quiet_ready", {63'h0, o_ready}, 64'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised memory-access/writeback stage for the RISC-V core pipeline. It sits between Execute and the register file. It supports a variable-latency data memory through a response handshake, and stalls Execute while a load is outstanding. It aligns and sign/zero-extends load data for XLEN 32 or 64, and selects among ALU, load, PC+4 and CSR write-back sources. The result is registered and presented to the register file and forwarding network for exactly one cycle per retired instruction.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- TIMEOUT, 64, max cycles waiting for a load response before aborting (≥2)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  Execute presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_pc  in  XLEN  PC of the instruction
- ex_alu_out  in  XLEN  ALU result / load address
- ex_rd  in  5  destination register (inst[11:7])
- ex_wb_sel  in  2  00 ALU, 01 DMEM, 10 PC+4, 11 CSR
- ex_ld_sel  in  3  funct3 load type
- ex_reg_wen  in  1  instruction writes rd
- csr_rdata  in  XLEN  CSR read data, valid with ex_valid
- dmem_resp_valid  in  1  load data valid this cycle
- dmem_rdata  in  XLEN  raw memory word
- wb_valid  out  1  one-cycle retire pulse
- wb_wen  out  1  register-file write enable
- wb_rd  out  5  write address
- wb_data  out  XLEN  write data
- wb_err  out  1  one-cycle load-timeout/spurious-response pulse

## Operation
- Accept when ex_valid && ex_ready. ex_ready = (state == IDLE).
- FSM states:
  - IDLE:
    - non-load accept (wb_sel ≠ 01): compute result, register it, stay in IDLE.
    - load accept (wb_sel == 01): latch rd, reg_wen, ld_sel, byte offset = ex_alu_out[log2(XLEN/8)-1:0]; clear the wait counter; go to WAIT.
  - WAIT:
    - ex_ready = 0.
    - On dmem_resp_valid: register the extended data and return to IDLE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1: wb_valid=1, wb_wen=0, wb_err=1; return to IDLE.
- Source mux: ALU → ex_alu_out; PC+4 → ex_pc + 4 (modulo 2^XLEN); CSR → csr_rdata; DMEM → extended load.
- Load extension, shift by offset×8:
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the halfword.
  - 010 LW: sign-extend to XLEN (identity when XLEN=32).
  - 011 LD: full word; XLEN=64 only.
  - 100 LBU, 101 LHU: zero-extend.
  - 110 LWU: zero-extend; XLEN=64 only.
  - Any other code, including 011/110 when XLEN=32: data 0 and wb_err pulse.
- wb_wen = reg_wen && rd ≠ 0 && !err.
- dmem_resp_valid in IDLE is spurious: pulse wb_err. No write-back and no state change. Any simultaneous non-load accept proceeds normally.
- Misalignment is not checked in this stage; offset bits are used as given.

## Timing
- Reset: state IDLE, counter 0, wb_valid/wb_wen/wb_err 0, wb_rd 0, wb_data 0; ex_ready 1 in the cycle after rst deasserts.
- Non-load latency: accepted in cycle N, wb_* valid in cycle N+1.
- Load latency: accepted in cycle N; earliest response in N+1; wb_* valid in the cycle after the response. A response in cycle N is not consumed.
- Back-to-back non-loads retire every cycle. A load blocks acceptance from N+1 until the cycle after the response.
- Load response and new accept: the response cycle still has ex_ready=0. The next instruction can be accepted one cycle later, while the load result is on wb_*.
- rst while in WAIT: abort immediately, no write-back, no wb_err.
- All outputs are registered; no combinational path from dmem_* to wb_*. ex_ready is decoded combinationally from state only.

## Structure
- Shared core package holds:
  - WB_ALU/WB_DMEM/WB_PC4/WB_CSR encodings
  - LD_* funct3 constants
  - state enum {IDLE, WAIT}
- Sub-module load_align: combinational; parameter XLEN; inputs offset, ld_sel, raw word; outputs extended data and illegal flag.

## Test plan
- ADDI result 0x0000_1234, rd=5, ALU source → next cycle wb_valid=1, wb_wen=1, wb_rd=5, wb_data=0x0000_1234.
- LB, alu_out=0x103, dmem_rdata=0x80FF_0000, response after 3 cycles → ex_ready low for 3 cycles; then wb_data=0xFFFF_FF80.
- LHU, offset 2, rdata=0xBEEF_0000 → 0x0000_BEEF. Same with LH → 0xFFFF_BEEF.
- JAL, pc=0xFFFF_FFFC, PC+4 source → wb_data=0x0000_0000 (wrap-around). rd=0 → wb_wen=0, wb_valid=1.
- Load with no response for TIMEOUT=4 cycles → wb_valid=1, wb_err=1, wb_wen=0; ex_ready=1 in the next cycle.
- XLEN=64: LD, rdata=0x8000_0000_0000_0001 → identical. LWU, offset 4 → 0x0000_0000_8000_0000. rst asserted in WAIT → no wb_valid.
